// File: rtl/array_feeder_pkg.sv
// rtl/array_feeder_pkg.sv - shared mini-TPU parameters and feeder FSM encoding
package array_feeder_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int N           = 4;
    localparam int FEED_CYCLES = 3 * N - 2;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } feed_state_t;

endpackage

// File: rtl/array_feeder_buf.sv
// rtl/array_feeder_buf.sv - feeder_buf: N x N line store with N diagonal read lanes
module feeder_buf #(
    parameter int DATA_WIDTH = array_feeder_pkg::DATA_WIDTH,
    parameter int N          = array_feeder_pkg::N,
    parameter int CNT_W      = array_feeder_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(N)-1:0]    wr_idx,
    input  logic [N*DATA_WIDTH-1:0] wr_data,
    input  logic [CNT_W-1:0]        t,
    output logic [N*DATA_WIDTH-1:0] lanes
);

    localparam int IDX_W = $clog2(N);

    logic [DATA_WIDTH-1:0] mem     [N][N];
    logic [DATA_WIDTH-1:0] mem_nxt [N][N];

    always_comb begin
        mem_nxt = mem;
        if (wr_en) begin
            for (int k = 0; k < N; k++) begin
                mem_nxt[wr_idx][k] = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    mem[i][k] <= '0;
                end
            end
        end else begin
            mem <= mem_nxt;
        end
    end

    // Lane i walks line i delayed by i counts; it reads the post-write view so
    // a write landing on the same edge as the launch is already visible.
    always_comb begin
        lanes = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(t) >= i && int'(t) < i + N) begin
                lanes[i*DATA_WIDTH +: DATA_WIDTH] = mem_nxt[i][IDX_W'(int'(t) - i)];
            end
        end
    end

endmodule

// File: rtl/array_feeder.sv
// rtl/array_feeder.sv - skewed A/B feeder for the systolic array with registered outputs
module array_feeder #(
    parameter int DATA_WIDTH = array_feeder_pkg::DATA_WIDTH,
    parameter int N          = array_feeder_pkg::N
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [1:0]              wr_idx,
    input  logic [N*DATA_WIDTH-1:0] wr_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [N*DATA_WIDTH-1:0] a_out,
    output logic [N*DATA_WIDTH-1:0] b_out,
    output logic                    we
);

    import array_feeder_pkg::*;

    feed_state_t             state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [N*DATA_WIDTH-1:0] a_lanes, b_lanes;
    logic                    buf_open;

    assign buf_open = (state != FEED);

    // B is stored column-major so both buffers share the same diagonal read.
    feeder_buf #(.DATA_WIDTH(DATA_WIDTH), .N(N), .CNT_W(CNT_W)) u_buf_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && !wr_sel && buf_open),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .t       (cnt_nxt),
        .lanes   (a_lanes)
    );

    feeder_buf #(.DATA_WIDTH(DATA_WIDTH), .N(N), .CNT_W(CNT_W)) u_buf_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && wr_sel && buf_open),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .t       (cnt_nxt),
        .lanes   (b_lanes)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        unique case (state)
            IDLE, DONE: state_nxt = start ? FEED : IDLE;
            FEED: begin
                if (cnt == CNT_W'(FEED_CYCLES - 1)) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            we    <= 1'b0;
            done  <= 1'b0;
            a_out <= '0;
            b_out <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt == FEED);
            we    <= (state_nxt == FEED);
            done  <= (state_nxt == DONE);
            a_out <= (state_nxt == FEED) ? a_lanes : '0;
            b_out <= (state_nxt == FEED) ? b_lanes : '0;
        end
    end

endmodule

// File: tb/tb_array_feeder.sv
// tb/tb_array_feeder.sv - self-checking bench for array_feeder
module tb_array_feeder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [1:0]  wr_idx = 2'd0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic        busy, done, we;
    logic [31:0] a_out, b_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int ma [4][4];
    int mb [4][4];
    int m_t = 0;
    bit m_feed = 0;
    bit m_done = 0;

    vec_t        tbl [10];
    logic [31:0] a_hist [10];
    logic [31:0] b_hist [10];

    always #5 clk = ~clk;

    array_feeder #(.DATA_WIDTH(8), .N(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .a_out   (a_out),
        .b_out   (b_out),
        .we      (we)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_a();
        logic [31:0] e = '0;
        if (m_feed)
            for (int i = 0; i < 4; i++)
                if (m_t - i >= 0 && m_t - i < 4) e[i*8 +: 8] = 8'(ma[i][m_t - i]);
        return e;
    endfunction

    function automatic logic [31:0] exp_b();
        logic [31:0] e = '0;
        if (m_feed)
            for (int j = 0; j < 4; j++)
                if (m_t - j >= 0 && m_t - j < 4) e[j*8 +: 8] = 8'(mb[m_t - j][j]);
        return e;
    endfunction

    task automatic cycle(input bit w, input bit sel, input int idx, input logic [31:0] data,
                         input bit st, input bit rn);
        wr_en = w; wr_sel = sel; wr_idx = 2'(idx); wr_data = data; start = st; rst_n = rn;
        @(posedge clk);
        cyc++;
        if (!rn) begin
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) begin ma[i][k] = 0; mb[i][k] = 0; end
            m_feed = 0; m_done = 0; m_t = 0;
        end else if (m_feed) begin
            if (m_t == 9) begin m_feed = 0; m_done = 1; end
            else m_t++;
        end else begin
            m_done = 0;
            if (w)
                for (int k = 0; k < 4; k++)
                    if (!sel) ma[idx][k] = int'(data[k*8 +: 8]);
                    else      mb[k][idx] = int'(data[k*8 +: 8]);
            if (st) begin m_feed = 1; m_t = 0; end
        end
        #1;
        check("busy", 32'(busy), 32'(m_feed));
        check("we", 32'(we), 32'(m_feed));
        check("done", 32'(done), 32'(m_done));
        check("a_out", a_out, exp_a());
        check("b_out", b_out, exp_b());
    endtask

    task automatic idle();
        cycle(0, 0, 0, '0, 0, 1);
    endtask

    // Counts edges after the launch edge until done is seen; -1 on timeout.
    task automatic feed_wait(input int already, output int n);
        n = already;
        for (int k = 0; k < 30; k++) begin
            idle();
            n++;
            if (done) return;
        end
        n = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int acc;
        logic [31:0] orv;
        int wcnt;

        tbl[0] = '{32'h00000000, 32'h00000002};
        tbl[1] = '{32'h00001001, 32'h00000202};
        tbl[2] = '{32'h00201102, 32'h00020202};
        tbl[3] = '{32'h30211203, 32'h02020202};
        tbl[4] = '{32'h31221300, 32'h02020200};
        tbl[5] = '{32'h32230000, 32'h02020000};
        tbl[6] = '{32'h33000000, 32'h02000000};
        tbl[7] = '{32'h00000000, 32'h00000000};
        tbl[8] = '{32'h00000000, 32'h00000000};
        tbl[9] = '{32'h00000000, 32'h00000000};

        cycle(0, 0, 0, '0, 0, 0);
        cycle(0, 0, 0, '0, 0, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_outs", a_out | b_out, 0);

        // Identity A, B[k][j] = 4k+j+1: downstream product must reproduce B.
        for (int i = 0; i < 4; i++) cycle(1, 0, i, 32'(1) << (8 * i), 0, 1);
        for (int j = 0; j < 4; j++)
            cycle(1, 1, j, {8'(13 + j), 8'(9 + j), 8'(5 + j), 8'(1 + j)}, 0, 1);
        for (int t = 0; t < 10; t++) begin
            cycle(0, 0, 0, '0, t == 0, 1);
            a_hist[t] = a_out;
            b_hist[t] = b_out;
            check("a_row0_seq", 32'(a_out[7:0]), (t == 0) ? 32'd1 : 32'd0);
        end
        idle();
        check("done_at_s11", 32'(done), 1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int tt = 0; tt < 20; tt++)
                    if (tt - j >= 0 && tt - j < 10 && tt - i >= 0 && tt - i < 10)
                        acc += int'(a_hist[tt - j][i*8 +: 8]) * int'(b_hist[tt - i][j*8 +: 8]);
                check("c_equals_b", 32'(acc), 32'(4 * i + j + 1));
            end

        // A[i][k] = 16i+k, B all 2: table of per-count outputs.
        for (int i = 0; i < 4; i++)
            cycle(1, 0, i, {8'(16*i+3), 8'(16*i+2), 8'(16*i+1), 8'(16*i)}, 0, 1);
        for (int j = 0; j < 4; j++) cycle(1, 1, j, 32'h02020202, 0, 1);
        for (int t = 0; t < 10; t++) begin
            cycle(0, 0, 0, '0, t == 0, 1);
            check("tbl_a", a_out, tbl[t].a);
            check("tbl_b", b_out, tbl[t].b);
            check("tbl_we", 32'(we), 1);
        end
        feed_wait(9, n);
        check("tbl_done_latency", 32'(n), 32'd10);

        // start and write during FEED are ignored.
        cycle(0, 0, 0, '0, 1, 1);
        idle();
        idle();
        cycle(0, 0, 0, '0, 1, 1);
        cycle(1, 0, 0, 32'hffffffff, 0, 1);
        feed_wait(4, n);
        check("ignore_done_latency", 32'(n), 32'd10);
        idle();
        check("ignore_no_refeed", 32'(busy), 0);
        cycle(0, 0, 0, '0, 1, 1);
        idle();
        check("a_row0_unchanged", a_out, 32'h00001001);
        feed_wait(1, n);
        check("refeed_latency", 32'(n), 32'd10);

        // Reset mid-FEED.
        cycle(0, 0, 0, '0, 1, 1);
        for (int k = 0; k < 4; k++) idle();
        cycle(0, 0, 0, '0, 0, 0);
        check("midrst_busy_we", 32'({busy, we}), 0);
        check("midrst_outs", a_out | b_out, 0);
        check("midrst_done", 32'(done), 0);
        for (int k = 0; k < 12; k++) idle();
        orv = '0; wcnt = 0;
        cycle(0, 0, 0, '0, 1, 1);
        orv |= a_out | b_out; wcnt += int'(we);
        for (int k = 0; k < 9; k++) begin idle(); orv |= a_out | b_out; wcnt += int'(we); end
        check("zero_feed", orv, 0);
        check("zero_feed_we", 32'(wcnt), 32'd10);
        idle();

        // start held through DONE: back-to-back feeds.
        cycle(0, 0, 0, '0, 1, 1);
        for (int e = 1; e <= 21; e++) begin
            cycle(0, 0, 0, '0, e <= 11, 1);
            check("b2b_we", 32'(we), 32'((e <= 9) || (e >= 11 && e <= 20)));
            check("b2b_done", 32'(done), 32'(e == 10 || e == 21));
        end
        idle();

        // Write and start on the first edge after reset.
        cycle(0, 0, 0, '0, 0, 0);
        cycle(1, 0, 3, 32'h09090909, 1, 1);
        check("same_edge_t0", 32'(a_out[31:24]), 0);
        for (int t = 1; t < 10; t++) begin
            idle();
            check("same_edge_a3", 32'(a_out[31:24]), (t >= 3 && t <= 6) ? 32'd9 : 32'd0);
        end
        feed_wait(9, n);
        check("same_edge_latency", 32'(n), 32'd10);

        for (int k = 0; k < 1500; k++)
            cycle($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, int'($urandom_range(3, 0)),
                  32'($urandom), $urandom_range(9, 0) == 0, $urandom_range(99, 0) != 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/array_feeder.md
ARRAY_FEEDER -- requirements
Module: array_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, element width of A and B; SHALL equal the systolic array's DATA_WIDTH.
REQ-002 Parameter N, default 4, array dimension; SHALL be fixed at 4 for this release.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 wr_en  input  1  buffer write strobe.
REQ-006 wr_sel  input  1  write target: 0 = A row buffer, 1 = B column buffer.
REQ-007 wr_idx  input  2  row index of A, or column index of B.
REQ-008 wr_data  input  N*DATA_WIDTH  byte k = A[wr_idx][k] (wr_sel=0), or B[k][wr_idx] (wr_sel=1).
REQ-009 start  input  1  request one skewed feed of the buffered A and B.
REQ-010 busy  output  1  high while a feed is in progress.
REQ-011 done  output  1  one-cycle pulse when a feed completes.
REQ-012 a_out  output  N*DATA_WIDTH  byte i drives array row i activation input.
REQ-013 b_out  output  N*DATA_WIDTH  byte j drives array column j weight input.
REQ-014 we  output  1  MAC enable to the array.

Function
REQ-015 The block SHALL hold two N x N DATA_WIDTH buffers, A and B, written only via wr_en.
REQ-016 A write SHALL take effect at the next edge only when state is IDLE or DONE; writes during FEED SHALL be ignored.
REQ-017 The FSM SHALL have states IDLE, FEED, DONE; reset state IDLE.
REQ-018 IDLE or DONE with start=1 SHALL go to FEED with counter t=0; start in FEED SHALL be ignored.
REQ-019 FEED SHALL last exactly 3N-2 = 10 cycles (t=0..9), then go to DONE; DONE SHALL last one cycle, then go to IDLE unless start=1.
REQ-020 In FEED at count t, a_out byte i SHALL be A[i][t-i] if 0 <= t-i < N, else 0.
REQ-021 In FEED at count t, b_out byte j SHALL be B[t-j][j] if 0 <= t-j < N, else 0.
REQ-022 we SHALL be 1 exactly in FEED cycles and 0 otherwise; a_out and b_out SHALL be 0 outside FEED.
REQ-023 a_out, b_out, we, busy and done SHALL be registered outputs.
REQ-024 Latency: start sampled at edge S SHALL produce busy=we=1 for cycles S+1..S+10 and done=1 in cycle S+11 only.
REQ-025 Simultaneous wr_en and start in IDLE/DONE: the write SHALL be applied and be visible to the feed that start launches.
REQ-026 start in the DONE cycle SHALL launch a new feed with no idle cycle between (back-to-back; done=1 and we=1 never in the same cycle).
REQ-027 Counter SHALL be 4 bits, SHALL not wrap within a feed, and SHALL clear to 0 on leaving FEED.

Reset
REQ-028 rst_n=0 at an edge SHALL force state IDLE, counter 0, busy=done=we=0, a_out=b_out=0 and both buffers to 0, including mid-FEED (no done pulse issued).
REQ-029 The first edge with rst_n=1 SHALL accept wr_en and start normally.

Structure
REQ-030 DATA_WIDTH, N, FEED_CYCLES (3N-2) and the FSM state encoding SHALL live in the shared mini-TPU package used by the array.
REQ-031 One sub-module, feeder_buf (N x N register file with one row/column write port and N parallel diagonal read lanes), SHALL hold each of A and B; FSM and skew muxing remain in array_feeder.

Verification
REQ-032 A = identity, B[k][j] = 4k+j+1, start -> after feed the downstream array C equals B; a_out sequence row0 = 1,0,0,...; done in cycle S+11.
REQ-033 A[i][k] = 16i+k, B = all 2, observe t=2 -> a_out bytes {0x02,0x11,0x20,0x00}, b_out bytes {2,2,2,0}.
REQ-034 start asserted again at S+3 and wr_en to A row 0 at S+4 -> no effect; busy falls and done pulses exactly as in a single feed; A unchanged.
REQ-035 rst_n=0 at S+5 -> next cycle busy=we=0, outputs 0, no done pulse; subsequent start feeds all zeros.
REQ-036 start held high through DONE -> second feed begins at S+12, we high S+12..S+21, done at S+22, no gap.
REQ-037 wr_en (A row 3 = {9,9,9,9}) and start in the same IDLE cycle -> at t=3..6 a_out byte 3 = 9.
